tlb_op_ctrl: RTL

//  Sequencer for TLBR/TLBWI/TLBWR/TLBP, sitting between the CP0/pipeline and the TLB array.

---
 rtl/tlb_op_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer for TLBR/TLBWI/TLBWR/TLBP between CP0/pipeline and the TLB array.
// Owns CP0 Index/Random/Wired, drives the TLB write/index side, captures read/probe results.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   op_valid/op_code/op_ready      TLB instruction handshake (00 R, 01 WI, 10 WR, 11 P)
//   op_done, tlb_flush             completion pulse, post-write flush pulse
//   idx_wr, wired_wr, cp0_wdata    mtc0 Index/Wired writes
//   index_o, random_o, wired_o     CP0 register views
//   tlb_we, tlb_index              TLB write enable / entry select
//   tlb_probe, tlb_mask/hi/lo0/lo1 TLB probe and read results
//   rd_we, rd_mask/hi/lo0/lo1      captured TLBR results for CP0
module tlb_op_ctrl #(
  parameter int unsigned TLB_NUM  = 32,
  parameter int unsigned IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [1:0]          op_code,
  output logic                op_ready,
  output logic                op_done,
  output logic                tlb_flush,
  input  logic                idx_wr,
  input  logic                wired_wr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         index_o,
  output logic [31:0]         random_o,
  output logic [31:0]         wired_o,
  output logic                tlb_we,
  output logic [IDX_BITS-1:0] tlb_index,
  input  logic [31:0]         tlb_probe,
  input  logic [11:0]         tlb_mask,
  input  logic [31:0]         tlb_hi,
  input  logic [31:0]         tlb_lo0,
  input  logic [31:0]         tlb_lo1,
  output logic                rd_we,
  output logic [11:0]         rd_mask,
  output logic [31:0]         rd_hi,
  output logic [31:0]         rd_lo0,
  output logic [31:0]         rd_lo1
);

  localparam logic [IDX_BITS-1:0] RAND_TOP = IDX_BITS'(TLB_NUM - 1);
  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_op;
  logic [IDX_BITS-1:0] r_idx;
  logic [IDX_BITS-1:0] r_random, w_random_nxt;
  logic [IDX_BITS-1:0] r_wired;
  logic                r_index_p;
  logic [IDX_BITS-1:0] r_index_idx;
  logic                r_probe_miss;
  logic [IDX_BITS-1:0] r_probe_idx;
  logic                r_op_ready, r_op_done, r_tlb_flush, r_tlb_we, r_rd_we;
  logic                w_accept, w_we_nxt, w_done_nxt, w_rdwe_nxt, w_flush_nxt;
  logic                w_unused;

  // Bits of the mtc0 data and probe word that the Index format discards.
  assign w_unused = ^{cp0_wdata[30:IDX_BITS], tlb_probe[30:IDX_BITS]};

  // Next-state and pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_rdwe_nxt  = 1'b0;
    w_flush_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
          w_we_nxt    = (op_code == OP_TLBWI) || (op_code == OP_TLBWR);
        end
      end
      S_EXEC: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
        w_rdwe_nxt  = (r_op == OP_TLBR);
        w_flush_nxt = (r_op == OP_TLBWI) || (r_op == OP_TLBWR);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Random counts down and wraps to the top once it reaches Wired.
  always_comb begin
    w_random_nxt = r_random - IDX_BITS'(1);
    if (wired_wr || (r_random <= r_wired)) begin
      w_random_nxt = RAND_TOP;
    end
  end

  // Sequencer state, latched operation and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_TLBR;
      r_idx       <= '0;
      r_op_ready  <= 1'b1;
      r_op_done   <= 1'b0;
      r_tlb_flush <= 1'b0;
      r_tlb_we    <= 1'b0;
      r_rd_we     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op_ready  <= (w_state_nxt == S_IDLE);
      r_op_done   <= w_done_nxt;
      r_tlb_flush <= w_flush_nxt;
      r_tlb_we    <= w_we_nxt;
      r_rd_we     <= w_rdwe_nxt;
      if (w_accept) begin
        r_op  <= op_code;
        r_idx <= (op_code == OP_TLBWR) ? r_random : r_index_idx;
      end
    end
  end

  // CP0 Random/Wired/Index; a completing TLBP overrides a same-cycle mtc0 Index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_random    <= RAND_TOP;
      r_wired     <= '0;
      r_index_p   <= 1'b0;
      r_index_idx <= '0;
    end else begin
      r_random <= w_random_nxt;
      if (wired_wr) begin
        r_wired <= cp0_wdata[IDX_BITS-1:0];
      end
      if ((r_state == S_DONE) && (r_op == OP_TLBP)) begin
        r_index_p   <= r_probe_miss;
        r_index_idx <= r_probe_idx;
      end else if (idx_wr) begin
        r_index_p   <= cp0_wdata[31];
        r_index_idx <= cp0_wdata[IDX_BITS-1:0];
      end
    end
  end

  // Capture of TLB read / probe results during EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_mask      <= '0;
      rd_hi        <= '0;
      rd_lo0       <= '0;
      rd_lo1       <= '0;
      r_probe_miss <= 1'b0;
      r_probe_idx  <= '0;
    end else if (r_state == S_EXEC) begin
      if (r_op == OP_TLBR) begin
        rd_mask <= tlb_mask;
        rd_hi   <= tlb_hi;
        rd_lo0  <= tlb_lo0;
        rd_lo1  <= tlb_lo1;
      end
      if (r_op == OP_TLBP) begin
        r_probe_miss <= tlb_probe[31];
        r_probe_idx  <= tlb_probe[IDX_BITS-1:0];
      end
    end
  end

  assign op_ready  = r_op_ready;
  assign op_done   = r_op_done;
  assign tlb_flush = r_tlb_flush;
  assign tlb_we    = r_tlb_we;
  assign rd_we     = r_rd_we;
  assign tlb_index = r_idx;
  assign index_o   = {r_index_p, {(31 - IDX_BITS){1'b0}}, r_index_idx};
  assign random_o  = 32'(r_random);
  assign wired_o   = 32'(r_wired);

endmodule
